// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the DMEM responder slice.
//   - dmem_state_e : responder FSM states (zero-fill sweep, then serving)
//   - DMEM_LANES   : byte lanes per 32-bit word
//   - DMEM_PAR_W   : parity bits stored per lane (1 with DMEM_PARITY_EN, else 0)
//   - DMEM_LANE_W  : stored bits per lane (byte + parity)
//   - byte_parity  : even-parity bit for one byte
// Optional feature macro: DMEM_PARITY_EN
package dmem_responder_pkg;

  typedef enum logic {
    DMEM_ST_CLEAR = 1'b0,
    DMEM_ST_READY = 1'b1
  } dmem_state_e;

  localparam int unsigned DMEM_LANES = 4;

`ifdef DMEM_PARITY_EN
  localparam int unsigned DMEM_PAR_W = 1;
`else
  localparam int unsigned DMEM_PAR_W = 0;
`endif

  localparam int unsigned DMEM_LANE_W = 8 + DMEM_PAR_W;

  // Even parity: the stored bit makes the 9-bit lane XOR to zero.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// One byte lane of the data memory: DEPTH_WORDS x WIDTH synchronous RAM
// with a registered, write-first read port.
// Ports:
//   clk      core clock
//   i_we     write enable for i_addr this cycle
//   i_addr   word index
//   i_wdata  lane data (plus parity bit when stored)
//   o_rdata  word[i_addr] as of the previous edge, post-write when i_we was set
module dmem_byte_bank #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline DMEM port. After reset it sweeps
// zeros through the whole array, then serves one access per cycle with a
// fixed one-cycle read latency and write-first read-during-write.
// Ports:
//   clk               core clock
//   DMEM_rst_i        synchronous active-high reset
//   DMEM_add_i        byte address (bits [1:0] ignored)
//   DMEM_byte_mark_i  per-lane write enables, 0 = read-only
//   DMEM_data_write_i lane-aligned write data
//   DMEM_data_o       word for the address of the previous cycle
//   DMEM_ready_o      zero-fill done, accesses honoured
//   DMEM_oob_o        previous-cycle address was outside the array
//   DMEM_par_err_o    sticky parity error (only with DMEM_PARITY_EN)
// Optional feature macro: DMEM_PARITY_EN
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  DMEM_rst_i,
  input  logic [31:0]           DMEM_add_i,
  input  logic [3:0]            DMEM_byte_mark_i,
  input  logic [DATA_WIDTH-1:0] DMEM_data_write_i,
  output logic [DATA_WIDTH-1:0] DMEM_data_o,
  output logic                  DMEM_ready_o,
`ifdef DMEM_PARITY_EN
  output logic                  DMEM_par_err_o,
`endif
  output logic                  DMEM_oob_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_e r_state, w_state_next;
  logic [AW-1:0] r_cnt;
  logic          r_rd_valid;
  logic          r_oob;

  logic [31:0]   w_off;
  logic [31:0]   w_word;
  logic          w_in_range;
  logic [AW-1:0] w_idx;

  logic [AW-1:0]                          w_bank_addr;
  logic [DMEM_LANES-1:0]                  w_bank_we;
  logic [DMEM_LANES-1:0][DMEM_LANE_W-1:0] w_lane_wdata;
  logic [DMEM_LANES-1:0][DMEM_LANE_W-1:0] w_lane_rdata;
  logic [DATA_WIDTH-1:0]                  w_rd_word;

  // Range check: an address below the base wraps to a huge offset, but the
  // explicit >= comparison keeps it out of range regardless of depth.
  assign w_off      = DMEM_add_i - BASE_ADDR;
  assign w_word     = w_off >> 2;
  assign w_in_range = (DMEM_add_i >= BASE_ADDR) && (w_word < 32'(DEPTH_WORDS));
  assign w_idx      = w_word[AW-1:0];

  always_ff @(posedge clk) begin
    if (DMEM_rst_i) begin
      r_state <= DMEM_ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == DMEM_ST_CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bank_addr  = w_idx;
    w_bank_we    = '0;
    w_lane_wdata = '0;
    unique case (r_state)
      DMEM_ST_CLEAR: begin
        // Zero-fill: all lanes written with data 0, parity 0.
        w_bank_addr = r_cnt;
        w_bank_we   = '1;
        if (r_cnt == AW'(DEPTH_WORDS - 1)) begin
          w_state_next = DMEM_ST_READY;
        end
      end
      DMEM_ST_READY: begin
        if (w_in_range) begin
          w_bank_we = DMEM_byte_mark_i;
        end
        for (int unsigned l = 0; l < DMEM_LANES; l++) begin
`ifdef DMEM_PARITY_EN
          w_lane_wdata[l] = {byte_parity(DMEM_data_write_i[8*l +: 8]),
                             DMEM_data_write_i[8*l +: 8]};
`else
          w_lane_wdata[l] = DMEM_data_write_i[8*l +: 8];
`endif
        end
      end
      default: w_state_next = DMEM_ST_CLEAR;
    endcase
    // Reset wins over any access in the same cycle.
    if (DMEM_rst_i) begin
      w_bank_we    = '0;
      w_state_next = DMEM_ST_CLEAR;
    end
  end

  for (genvar l = 0; l < DMEM_LANES; l++) begin : g_lane
    dmem_byte_bank #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .WIDTH       (DMEM_LANE_W),
      .AW          (AW)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_bank_we[l]),
      .i_addr  (w_bank_addr),
      .i_wdata (w_lane_wdata[l]),
      .o_rdata (w_lane_rdata[l])
    );
  end

  // Tracks whether the bank output registers hold a valid READY read;
  // otherwise the data port is forced to zero.
  always_ff @(posedge clk) begin
    if (DMEM_rst_i) begin
      r_rd_valid <= 1'b0;
      r_oob      <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == DMEM_ST_READY) && w_in_range;
      r_oob      <= (r_state == DMEM_ST_READY) && !w_in_range;
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int unsigned l = 0; l < DMEM_LANES; l++) begin
      w_rd_word[8*l +: 8] = w_lane_rdata[l][7:0];
    end
  end

  assign DMEM_data_o  = r_rd_valid ? w_rd_word : '0;
  assign DMEM_oob_o   = r_oob;
  assign DMEM_ready_o = (r_state == DMEM_ST_READY);

`ifdef DMEM_PARITY_EN
  logic w_par_now;
  logic r_par_sticky;

  always_comb begin
    w_par_now = 1'b0;
    for (int unsigned l = 0; l < DMEM_LANES; l++) begin
      w_par_now = w_par_now | (^w_lane_rdata[l]);
    end
    w_par_now = w_par_now & r_rd_valid;
  end

  always_ff @(posedge clk) begin
    if (DMEM_rst_i) begin
      r_par_sticky <= 1'b0;
    end else if (w_par_now) begin
      r_par_sticky <= 1'b1;
    end
  end

  // The live term aligns the flag with the faulty data word; the sticky
  // register holds it afterwards.
  assign DMEM_par_err_o = r_par_sticky | w_par_now;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned DEPTH       = 1024;
  localparam logic [31:0] BASE        = 32'h0000_0000;
  localparam int unsigned CORRUPT_IDX = 8;

  logic        clk = 1'b0;
  logic        DMEM_rst_i = 1'b1;
  logic [31:0] DMEM_add_i = '0;
  logic [3:0]  DMEM_byte_mark_i = '0;
  logic [31:0] DMEM_data_write_i = '0;
  logic [31:0] DMEM_data_o;
  logic        DMEM_ready_o;
  logic        DMEM_oob_o;
`ifdef DMEM_PARITY_EN
  logic        DMEM_par_err_o;
`endif

  dmem_responder #(
    .DATA_WIDTH  (32),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk               (clk),
    .DMEM_rst_i        (DMEM_rst_i),
    .DMEM_add_i        (DMEM_add_i),
    .DMEM_byte_mark_i  (DMEM_byte_mark_i),
    .DMEM_data_write_i (DMEM_data_write_i),
    .DMEM_data_o       (DMEM_data_o),
    .DMEM_ready_o      (DMEM_ready_o),
`ifdef DMEM_PARITY_EN
    .DMEM_par_err_o    (DMEM_par_err_o),
`endif
    .DMEM_oob_o        (DMEM_oob_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  int unsigned m_clr_cnt = 0;
  logic [31:0] exp_data = '0;
  logic        exp_oob  = 1'b0;
  logic        exp_par  = 1'b0;
  logic        m_corrupt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts outputs after the edge.
  task automatic step(input logic rst, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data);
    logic [31:0] bm;
    logic [31:0] merged;
    logic [31:0] off;
    int unsigned idx;
    logic        inr;
    DMEM_rst_i        = rst;
    DMEM_add_i        = addr;
    DMEM_byte_mark_i  = mask;
    DMEM_data_write_i = data;
    @(posedge clk);
    if (rst) begin
      m_clr_cnt = 0;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
      exp_data  = '0;
      exp_oob   = 1'b0;
      exp_par   = 1'b0;
      m_corrupt = 1'b0;
    end else if (m_clr_cnt < DEPTH) begin
      m_clr_cnt++;
      exp_data = '0;
      exp_oob  = 1'b0;
    end else begin
      off = addr - BASE;
      inr = (addr >= BASE) && ((off / 4) < DEPTH);
      if (inr) begin
        idx = off / 4;
        bm  = '0;
        for (int b = 0; b < 4; b++) if (mask[b]) bm = bm | (32'hFF << (8 * b));
        merged = (m_mem[idx] & ~bm) | (data & bm);
        m_mem[idx] = merged;
        exp_data = merged;
        exp_oob  = 1'b0;
        if (idx == CORRUPT_IDX && mask[2]) m_corrupt = 1'b0;
        if (idx == CORRUPT_IDX && m_corrupt) exp_par = 1'b1;
      end else begin
        exp_data = '0;
        exp_oob  = 1'b1;
      end
    end
    #1;
    check("data", DMEM_data_o, exp_data);
    check("oob", {31'b0, DMEM_oob_o}, {31'b0, exp_oob});
    check("ready", {31'b0, DMEM_ready_o}, {31'b0, m_clr_cnt >= DEPTH});
`ifdef DMEM_PARITY_EN
    check("par_err", {31'b0, DMEM_par_err_o}, {31'b0, exp_par});
`endif
  endtask

  task automatic rand_step(input int unsigned oob_pct);
    logic [31:0] a;
    if ($urandom_range(99, 0) < oob_pct)
      a = ($urandom_range(1, 0) == 1) ? (32'h1000 + $urandom_range(1023, 0)) : $urandom;
    else
      a = BASE + ($urandom_range(63, 0) << 2) + $urandom_range(3, 0);
    step(1'b0, a, 4'($urandom_range(15, 0)), $urandom);
  endtask

  // Releases reset and counts cycles until ready, bounded.
  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    while (!DMEM_ready_o && n < 2000) begin
      rand_step(20);
      n++;
    end
    check(tag, n, DEPTH);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    #2;
    repeat (3) step(1'b1, 32'h10, 4'hF, 32'hFFFF_FFFF);
    check("rst_data", DMEM_data_o, 32'h0);
    check("rst_ready", {31'b0, DMEM_ready_o}, 32'h0);

    wait_ready("ready_latency");

    // Freshly cleared memory reads zero
    for (int i = 0; i < 6; i++) step(1'b0, BASE + ($urandom_range(1023, 0) << 2), 4'h0, $urandom);

    // Directed: full write, read back, write-first partial merge
    step(1'b0, 32'h10, 4'b1111, 32'hDEADBEEF);
    step(1'b0, 32'h10, 4'b0000, 32'h0);
    check("readback", DMEM_data_o, 32'hDEADBEEF);
    step(1'b0, 32'h10, 4'b0100, 32'h00AA0000);
    check("wf_merge", DMEM_data_o, 32'hDEAABEEF);
    step(1'b0, 32'h13, 4'b0000, 32'h0);
    check("low_bits_ignored", DMEM_data_o, 32'hDEAABEEF);

    // Out of range: dropped, one-cycle flag
    step(1'b0, 32'h0, 4'b1111, 32'hCAFE0001);
    step(1'b0, 32'h1000, 4'b1111, 32'h12345678);
    check("oob_flag", {31'b0, DMEM_oob_o}, 32'h1);
    check("oob_data", DMEM_data_o, 32'h0);
    step(1'b0, 32'h0, 4'b0000, 32'h0);
    check("oob_not_sticky", {31'b0, DMEM_oob_o}, 32'h0);
    check("after_oob", DMEM_data_o, 32'hCAFE0001);
    step(1'b0, 32'hFFFF_FFFC, 4'b1111, 32'h1);
    check("oob_high", {31'b0, DMEM_oob_o}, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) rand_step(12);

`ifdef DMEM_PARITY_EN
    step(1'b0, 32'h20, 4'b1111, 32'h11223344);
    dut.g_lane[2].u_bank.r_mem[CORRUPT_IDX][0] = ~dut.g_lane[2].u_bank.r_mem[CORRUPT_IDX][0];
    m_mem[CORRUPT_IDX] = m_mem[CORRUPT_IDX] ^ 32'h0001_0000;
    m_corrupt = 1'b1;
    step(1'b0, 32'h20, 4'b0000, 32'h0);
    check("par_detect", {31'b0, DMEM_par_err_o}, 32'h1);
    for (int i = 0; i < 20; i++) rand_step(10);
    check("par_sticky", {31'b0, DMEM_par_err_o}, 32'h1);
`endif

    // Reset mid-CLEAR restarts the full sweep
    step(1'b1, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 500; i++) rand_step(20);
    step(1'b1, 32'h40, 4'hF, 32'h55555555);
    wait_ready("ready_after_restart");
    step(1'b0, 32'h40, 4'h0, 32'h0);
    check("cleared_after_restart", DMEM_data_o, 32'h0);
    for (int i = 0; i < 100; i++) rand_step(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the pipeline's DMEM port.
- Accepts a word-aligned address, a 4-bit byte mask and pre-lane-aligned write data every cycle. Returns the full 32-bit word one clock later for the MEM stage's load-extraction logic.
- After reset it runs a zero-fill sweep and signals readiness.
- Owns the SRAM array, read-during-write forwarding and out-of-range handling.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 supported.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  core clock
- DMEM_rst_i  input  1  reset: synchronous, active-high
- DMEM_add_i  input  32  byte address; bits [1:0] ignored (word-aligned)
- DMEM_byte_mark_i  input  4  byte write enables; lane i = bits [8i+7:8i]; 0 = read-only cycle
- DMEM_data_write_i  input  32  write data, already placed in the target lanes
- DMEM_data_o  output  32  read word for the address presented in the previous cycle
- DMEM_ready_o  output  1  1 = zero-fill complete, accesses honoured
- DMEM_oob_o  output  1  registered; 1 = previous-cycle address fell outside the array

Behaviour:
- Reset: while DMEM_rst_i=1 on a clock edge:
  - DMEM_data_o <= 0, DMEM_ready_o <= 0, DMEM_oob_o <= 0.
  - Sweep counter <= 0; FSM <= CLEAR.
  - Last-write forwarding register invalidated.
- FSM states: CLEAR, READY.
- CLEAR state:
  - Each cycle, write 32'h0 to word[cnt] and increment cnt.
  - When cnt == DEPTH_WORDS-1 has been written, go to READY next cycle.
  - Duration is exactly DEPTH_WORDS cycles after reset deasserts.
  - All inputs are ignored; DMEM_data_o = 0; DMEM_oob_o = 0.
- READY state: DMEM_ready_o = 1; no exit except reset.
- Reset asserted mid-CLEAR or in READY: restart CLEAR from cnt=0. Array contents need not be preserved.
- Index calculation: idx = (DMEM_add_i - BASE_ADDR) >> 2.
  - In range iff DMEM_add_i >= BASE_ADDR and idx < DEPTH_WORDS.
  - Subtraction is 32-bit unsigned; wrap-below-base counts as out of range.
- Write (READY, in range, byte_mark != 0):
  - At the clock edge, word[idx] lane i <= data lane i for each set bit.
  - Clear-mask lanes are unchanged.
- Read:
  - Every READY cycle, DMEM_data_o at edge N+1 = word[idx] as addressed at edge N.
  - Latency is exactly 1; there is no read enable.
- Read-during-write, same cycle and same idx: the returned word is the post-write merge (write-first). Written lanes come from DMEM_data_write_i; other lanes keep old contents.
- Back-to-back accesses are plain array reads; consecutive write-then-read of the same idx returns updated data.
- Out of range:
  - Writes are dropped.
  - Next-cycle DMEM_data_o = 32'h0 and DMEM_oob_o = 1 for one cycle.
  - This is not sticky.
- Simultaneous reset and access: reset wins, and the access is dropped.
- No stall output: the responder never back-pressures once READY. The core must hold off memory operations until DMEM_ready_o=1.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Enabled:
  - One even-parity bit is stored per byte lane and written with each lane. CLEAR writes parity 0.
  - On every read in READY, parity is recomputed per lane.
  - A mismatch sets extra output DMEM_par_err_o (1 bit). It is registered, sticky until reset, and aligned with the DMEM_data_o it applies to.
  - A write-first forwarded read uses the merged parity.
- Disabled: no parity storage; the DMEM_par_err_o port does not exist.

Decomposition:
- The shared include (alongside the existing memory-op defines) holds:
  - FSM state encodings DMEM_ST_CLEAR / DMEM_ST_READY;
  - the lane-count constant DMEM_LANES = 4;
  - the parity-width constant.
- One natural sub-module, dmem_byte_bank:
  - a single byte-wide synchronous RAM (DEPTH_WORDS x 8, +1 parity bit when enabled) with write enable and write-first read;
  - instantiated four times, once per lane.
- The top level holds the FSM, range check, oob/err flags and output mux.

Test Plan:
- Reset, then hold DMEM_rst_i=0: DMEM_ready_o=0 for 1024 cycles, 1 on cycle 1025. Read of any in-range word returns 32'h0.
- Write 32'hDEADBEEF to addr 0x10 with mask 4'b1111; read 0x10 next cycle -> DMEM_data_o=32'hDEADBEEF one cycle after the read address.
- Then write 32'h00AA0000 with mask 4'b0100 to 0x10 while simultaneously reading 0x10 -> read returns 32'hDEAABEEF (write-first merge).
- Address 0x1000 (idx 1024) with mask 4'b1111 and data 32'h12345678 -> write dropped, DMEM_data_o=0, DMEM_oob_o=1 for exactly one cycle. A subsequent read of 0x0 is unaffected.
- Assert DMEM_rst_i at cycle 500 of CLEAR -> DMEM_ready_o stays 0, and ready rises exactly 1024 cycles after deassert.
- With DMEM_PARITY_EN defined: backdoor-flip one stored bit of lane 2 at addr 0x20, then read 0x20 -> DMEM_par_err_o=1 from that cycle on, until reset.
